// File: rtl/word_packer.sv
// word_packer: packs RATIO consecutive DATA_WIDTH input samples into one
// DATA_WIDTH*RATIO output word (lane 0 = first received), with a
// valid/ready handshake on both sides and a frame counter that raises
// out_last on every cfg_frame-th output word (cfg_frame = 0 disables it).
// Optional feature: define WORD_PACKER_FLUSH_EN to add a 'flush' input that
// emits a partially packed word (unfilled lanes zero) tagged out_last.
module word_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int RATIO      = 2,
    parameter int CNTR_WIDTH = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [CNTR_WIDTH-1:0]            cfg_frame,
`ifdef WORD_PACKER_FLUSH_EN
    input  logic                             flush,
`endif
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH*RATIO-1:0]      out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last
);

    localparam int              IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(RATIO - 1);

    // Lanes below the top one are staged here; the top lane comes straight
    // from in_data on the completing transfer.
    logic [RATIO-2:0][DATA_WIDTH-1:0] r_pack;
    logic [RATIO-1:0][DATA_WIDTH-1:0] r_out_data;
    logic [IDX_W-1:0]                 r_idx;
    logic [CNTR_WIDTH-1:0]            r_frame_cnt;
    logic                             r_out_valid;
    logic                             r_out_last;

    logic                             w_in_xfer;
    logic                             w_done;
    logic                             w_flush;
    logic                             w_load;
    logic                             w_frame_end;
    logic [RATIO-1:0][DATA_WIDTH-1:0] w_word;

    // The top lane can only be written if the output register is free or
    // draining this cycle; other lanes never stall.
    assign in_ready  = (r_idx != LAST) || !r_out_valid || out_ready;
    assign w_in_xfer = in_valid && in_ready;
    assign w_done    = w_in_xfer && (r_idx == LAST);

`ifdef WORD_PACKER_FLUSH_EN
    // Flush only when something is staged, no word completes anyway, and
    // the output register can take a new word this edge.
    assign w_flush = flush && (r_idx != '0) && !w_done && (!r_out_valid || out_ready);
`else
    assign w_flush = 1'b0;
`endif

    assign w_load      = w_done || w_flush;
    assign w_frame_end = (cfg_frame != '0) &&
                         (r_frame_cnt >= (cfg_frame - CNTR_WIDTH'(1)));

    // Assemble the word to load: full word on completion, or staged lanes
    // with zero fill on flush. An input accepted in the flush cycle is kept
    // as the next lane of the flushed word rather than dropped.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < RATIO - 1; k++) begin
            w_word[k] = r_pack[k];
        end
        w_word[RATIO-1] = in_data;
`ifdef WORD_PACKER_FLUSH_EN
        if (w_flush) begin
            for (int k = 0; k < RATIO - 1; k++) begin
                if (IDX_W'(k) < r_idx)
                    w_word[k] = r_pack[k];
                else if ((IDX_W'(k) == r_idx) && w_in_xfer)
                    w_word[k] = in_data;
                else
                    w_word[k] = '0;
            end
            w_word[RATIO-1] = '0;
        end
`endif
    end

    // Stage non-final lanes; contents are don't-care across reset.
    always_ff @(posedge aclk) begin
        if (w_in_xfer && !w_done) begin
            for (int k = 0; k < RATIO - 1; k++) begin
                if (r_idx == IDX_W'(k))
                    r_pack[k] <= in_data;
            end
        end
    end

    // Lane index: advance per accepted sample, restart on load or reset.
    always_ff @(posedge aclk) begin
        if (!aresetn)
            r_idx <= '0;
        else if (w_load)
            r_idx <= '0;
        else if (w_in_xfer)
            r_idx <= r_idx + IDX_W'(1);
    end

    // Output data register; only written on a load so it holds while stalled.
    always_ff @(posedge aclk) begin
        if (w_load)
            r_out_data <= w_word;
    end

    // Output valid, last tag and frame counter.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            if (w_flush) begin
                r_out_last  <= 1'b1;
                r_frame_cnt <= '0;
            end else if (cfg_frame == '0) begin
                r_out_last  <= 1'b0;
                r_frame_cnt <= '0;
            end else if (w_frame_end) begin
                r_out_last  <= 1'b1;
                r_frame_cnt <= '0;
            end else begin
                r_out_last  <= 1'b0;
                r_frame_cnt <= r_frame_cnt + CNTR_WIDTH'(1);
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16: input word width in bits.
REQ-002 The module SHALL have parameter RATIO, default 2: input words packed per output word; legal values 2, 4, 8.
REQ-003 The module SHALL have parameter CNTR_WIDTH, default 16: width of the frame-length configuration and frame counter.
REQ-004 Port aclk, input, 1: clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port aresetn, input, 1: reset, synchronous, active-low.
REQ-006 Port cfg_frame, input, CNTR_WIDTH: output words per frame; 0 disables out_last.
REQ-007 Port in_data, input, DATA_WIDTH: input sample.
REQ-008 Port in_valid, input, 1: in_data valid.
REQ-009 Port in_ready, output, 1: module accepts in_data this cycle.
REQ-010 Port out_data, output, DATA_WIDTH*RATIO: packed word.
REQ-011 Port out_valid, output, 1: out_data valid.
REQ-012 Port out_ready, output... input, 1: downstream accepts out_data.
REQ-013 Port out_last, output, 1: out_data is the final word of a frame; qualified by out_valid.

Function
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-015 A lane index counter idx (0..RATIO-1) SHALL select the lane written by each input transfer; lane k occupies out_data bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH], lane 0 first-received.
REQ-016 For an input transfer with idx < RATIO-1, the module SHALL store in_data in lane idx of a pack register and increment idx.
REQ-017 For an input transfer with idx = RATIO-1, the module SHALL load out_data with in_data in the top lane and pack register lanes below it, set out_valid, and set idx to 0 on the same edge.
REQ-018 in_ready SHALL equal (idx != RATIO-1) OR NOT out_valid OR out_ready, combinationally; no combinational path from in_valid to in_ready.
REQ-019 Latency from the input transfer completing a word to out_valid high SHALL be exactly 1 cycle.
REQ-020 With in_valid and out_ready held high, the module SHALL sustain one input transfer per cycle and one output word every RATIO cycles.
REQ-021 out_valid SHALL clear after an output transfer unless a new word completes in the same cycle, in which case out_valid SHALL stay high with the new data.
REQ-022 out_data and out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-023 A frame counter SHALL count output words loaded; out_last SHALL be high for the loaded word when counter = cfg_frame-1, and the counter SHALL wrap to 0 on that load.
REQ-024 If cfg_frame changes mid-frame so that counter >= cfg_frame-1, the next loaded word SHALL carry out_last and the counter SHALL wrap.
REQ-025 With cfg_frame = 0, out_last SHALL stay low and the counter SHALL hold 0.

Reset
REQ-026 While aresetn is low, out_valid, out_last, idx and the frame counter SHALL be 0 at the next edge; pack register and out_data contents SHALL be don't-care.
REQ-027 Reset mid-word SHALL discard partially packed lanes; the first input after reset SHALL go to lane 0.

Configuration
REQ-028 With macro WORD_PACKER_FLUSH_EN defined, the module SHALL add input port flush (1 bit): when flush is high, idx > 0 and no input transfer completes a word, the next edge SHALL load the stored lanes with unfilled lanes zero, set out_valid and out_last, and reset idx and frame counter to 0, subject to the out_valid/out_ready stall of REQ-018.
REQ-029 Without WORD_PACKER_FLUSH_EN, port flush SHALL not exist and partial words SHALL persist until completed or reset.

Verification
REQ-030 RATIO=2, inputs 0x1111, 0x2222, out_ready=1 -> out_data=0x22221111, out_valid high 1 cycle after second transfer.
REQ-031 RATIO=4, cfg_frame=3, 24 consecutive inputs, out_ready=1 -> 6 outputs, out_last on outputs 3 and 6 only.
REQ-032 Output word pending, out_ready=0, idx=RATIO-1 -> in_ready=0, out_data unchanged until out_ready=1.
REQ-033 aresetn low after 1 of 2 lanes filled, then inputs 0xAAAA, 0xBBBB -> out_data=0xBBBBAAAA.
REQ-034 FLUSH_EN, RATIO=4, inputs 0x0001, 0x0002, flush -> out_data=0x0000000000020001, out_last=1.
